// File: rtl/acc_ctrl_seq.sv
// Instruction sequencer for the accumulator datapath: fetches 8-bit
// instructions over valid/ready, sequences operand reads, drives op strobes.
module acc_ctrl_seq #(
   parameter int PC_W        = 8,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic            clka,
   input  logic            restart,
   input  logic            start,
   input  logic            instr_valid,
   input  logic [7:0]      instr_data,
   output logic            instr_ready,
   output logic [PC_W-1:0] pc,
   output logic            mem_rd,
   output logic [3:0]      mem_addr,
   input  logic            mem_rdy,
   output logic            in_load_accu,
   output logic            in_arithMemory,
   output logic            execute_en_in,
   output logic [3:0]      in_imm,
   output logic            in_add,
   output logic            in_addi,
   output logic            in_sub,
   output logic            in_subi,
   output logic            in_and,
   output logic            in_or,
   output logic            in_xor,
   output logic            in_not,
   output logic            shiftl,
   output logic            shiftr,
   output logic            busy,
   output logic            halted,
   output logic            illegal,
   output logic            mem_err
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDA  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_ADDI = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_SUBI = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_XOR  = 4'h8;
   localparam logic [3:0] OP_NOT  = 4'h9;
   localparam logic [3:0] OP_SHL  = 4'hA;
   localparam logic [3:0] OP_SHR  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEMRD, S_EXEC, S_HALT
   } state_t;

   state_t           state;
   logic [7:0]       ir;
   logic [CNT_W-1:0] wait_cnt;
   logic [9:0]       op_strb;
   logic [3:0]       opc;

   assign opc = ir[7:4];

   // Bit order matches the output concatenation below: add is bit 0.
   function automatic logic [9:0] op_onehot(input logic [3:0] op);
      op_onehot = '0;
      case (op)
         OP_ADD:  op_onehot[0] = 1'b1;
         OP_ADDI: op_onehot[1] = 1'b1;
         OP_SUB:  op_onehot[2] = 1'b1;
         OP_SUBI: op_onehot[3] = 1'b1;
         OP_AND:  op_onehot[4] = 1'b1;
         OP_OR:   op_onehot[5] = 1'b1;
         OP_XOR:  op_onehot[6] = 1'b1;
         OP_NOT:  op_onehot[7] = 1'b1;
         OP_SHL:  op_onehot[8] = 1'b1;
         OP_SHR:  op_onehot[9] = 1'b1;
         default: op_onehot = '0;
      endcase
   endfunction

   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_XOR) || (op == OP_NOT);
   endfunction

   function automatic logic is_imm_op(input logic [3:0] op);
      return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_SHL) ||
             (op == OP_SHR)  || (op == OP_LDA);
   endfunction

   // Outputs are registered against the state being entered, so each one
   // is a clean function of the current state for the whole cycle.
   always_ff @(posedge clka) begin
      if (restart) begin
         state         <= S_IDLE;
         pc            <= '0;
         ir            <= '0;
         wait_cnt      <= '0;
         illegal       <= 1'b0;
         mem_err       <= 1'b0;
         instr_ready   <= 1'b0;
         mem_rd        <= 1'b0;
         mem_addr      <= '0;
         op_strb       <= '0;
         execute_en_in <= 1'b0;
         in_load_accu  <= 1'b0;
         in_imm        <= '0;
         busy          <= 1'b0;
         halted        <= 1'b0;
      end else begin
         instr_ready   <= 1'b0;
         mem_rd        <= 1'b0;
         mem_addr      <= '0;
         op_strb       <= '0;
         execute_en_in <= 1'b0;
         in_load_accu  <= 1'b0;
         in_imm        <= '0;
         busy          <= 1'b1;
         halted        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_FETCH;
                  instr_ready <= 1'b1;
               end else begin
                  busy <= 1'b0;
               end
            end
            S_FETCH: begin
               if (instr_valid) begin
                  ir    <= instr_data;
                  pc    <= pc + PC_W'(1);
                  state <= S_DECODE;
               end else begin
                  instr_ready <= 1'b1;
               end
            end
            S_DECODE: begin
               if (is_mem_op(opc)) begin
                  state    <= S_MEMRD;
                  mem_rd   <= 1'b1;
                  mem_addr <= ir[3:0];
               end else if (is_imm_op(opc)) begin
                  state         <= S_EXEC;
                  op_strb       <= op_onehot(opc);
                  execute_en_in <= (opc != OP_LDA);
                  in_load_accu  <= (opc == OP_LDA);
                  in_imm        <= ir[3:0];
               end else if (opc == OP_HALT) begin
                  state  <= S_HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else begin
                  // NOP, JMP and the undefined opcodes all go straight back to fetch.
                  if (opc == OP_JMP)
                     pc <= PC_W'(ir[3:0]);
                  if (opc != OP_NOP && opc != OP_JMP)
                     illegal <= 1'b1;
                  state       <= S_FETCH;
                  instr_ready <= 1'b1;
               end
            end
            S_MEMRD: begin
               if (mem_rdy) begin
                  wait_cnt      <= '0;
                  state         <= S_EXEC;
                  op_strb       <= op_onehot(opc);
                  execute_en_in <= 1'b1;
                  in_imm        <= ir[3:0];
               end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                  wait_cnt    <= '0;
                  mem_err     <= 1'b1;
                  state       <= S_FETCH;
                  instr_ready <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
                  mem_rd   <= 1'b1;
                  mem_addr <= ir[3:0];
               end
            end
            S_EXEC: begin
               state       <= S_FETCH;
               instr_ready <= 1'b1;
            end
            S_HALT: begin
               busy   <= 1'b0;
               halted <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Operand latch must fire in the very cycle reg_in is valid, so it is
   // the one output qualified by an input; it stays confined to MEMRD.
   assign in_arithMemory = (state == S_MEMRD) && mem_rdy;

   assign {shiftr, shiftl, in_not, in_xor, in_or,
           in_and, in_subi, in_sub, in_addi, in_add} = op_strb;

endmodule

// File: tb/tb_acc_ctrl_seq.sv
// Directed bench for acc_ctrl_seq (PC_W=4 so the pc wrap is reachable).
module tb_acc_ctrl_seq;

   logic       clka = 1'b0;
   logic       restart, start, instr_valid, mem_rdy;
   logic [7:0] instr_data;
   logic       instr_ready, mem_rd, in_load_accu, in_arithMemory, execute_en_in;
   logic [3:0] pc, mem_addr, in_imm;
   logic       in_add, in_addi, in_sub, in_subi, in_and, in_or, in_xor, in_not;
   logic       shiftl, shiftr, busy, halted, illegal, mem_err;
   logic [9:0] strb;
   logic [7:0] prog [16];
   int         n_err = 0;
   int         n_chk = 0;
   int         n_rd;
   int         n_hit;

   always #5 clka = ~clka;

   assign instr_data = prog[pc];
   assign strb = {shiftr, shiftl, in_not, in_xor, in_or,
                  in_and, in_subi, in_sub, in_addi, in_add};

   acc_ctrl_seq #(.PC_W(4), .MEM_TIMEOUT(15)) u_dut (
      .clka(clka), .restart(restart), .start(start),
      .instr_valid(instr_valid), .instr_data(instr_data),
      .instr_ready(instr_ready), .pc(pc), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_rdy(mem_rdy), .in_load_accu(in_load_accu),
      .in_arithMemory(in_arithMemory), .execute_en_in(execute_en_in),
      .in_imm(in_imm), .in_add(in_add), .in_addi(in_addi), .in_sub(in_sub),
      .in_subi(in_subi), .in_and(in_and), .in_or(in_or), .in_xor(in_xor),
      .in_not(in_not), .shiftl(shiftl), .shiftr(shiftr), .busy(busy),
      .halted(halted), .illegal(illegal), .mem_err(mem_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic do_reset();
      restart = 1'b1;
      tick();
      restart = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
      restart = 1'b1; start = 1'b0; instr_valid = 1'b0; mem_rdy = 1'b0;
      tick(); tick();
      restart = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_pc", pc, 0);
      chk("rst_ready", instr_ready, 0);
      chk("rst_flags", {illegal, mem_err}, 0);
      chk("rst_strb", {strb, execute_en_in, in_load_accu, mem_rd, mem_addr, in_imm}, 0);
      tick();
      chk("idle_hold", busy, 0);

      // ADDI 3 then HALT
      prog[0] = 8'h33; prog[1] = 8'hF0;
      instr_valid = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      chk("t1_fetch_ready", instr_ready, 1);
      chk("t1_fetch_pc", pc, 0);
      tick();
      chk("t1_dec_pc", pc, 1);
      chk("t1_dec_ready", instr_ready, 0);
      tick();
      chk("t1_exec_strb", strb, 10'h002);
      chk("t1_exec_en", execute_en_in, 1);
      chk("t1_exec_imm", in_imm, 3);
      tick();
      chk("t1_after_strb", {strb, execute_en_in}, 0);
      chk("t1_fetch2", {instr_ready, pc}, {1'b1, 4'd1});
      tick(); tick();
      chk("t1_halted", {halted, busy}, 2'b10);
      start = 1'b1; tick(); start = 1'b0;
      chk("t1_halt_sticky", {halted, busy, instr_ready}, 3'b100);

      // ADD addr 5, mem_rdy on third MEMRD cycle
      do_reset();
      prog[0] = 8'h25;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      chk("t2_rd1", {mem_rd, mem_addr, in_arithMemory}, {1'b1, 4'd5, 1'b0});
      tick();
      chk("t2_rd2", {mem_rd, mem_addr, in_arithMemory}, {1'b1, 4'd5, 1'b0});
      tick();
      mem_rdy = 1'b1; #1;
      chk("t2_rd3", {mem_rd, mem_addr, in_arithMemory}, {1'b1, 4'd5, 1'b1});
      tick(); mem_rdy = 1'b0;
      chk("t2_exec_strb", strb, 10'h001);
      chk("t2_exec_en", {execute_en_in, mem_rd, in_arithMemory}, 3'b100);

      // AND with no mem_rdy: timeout
      do_reset();
      prog[0] = 8'h62; prog[1] = 8'hF0;
      start = 1'b1; tick(); start = 1'b0;
      tick();
      n_rd = 0; n_hit = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (mem_rd) n_rd++;
         if (strb != 0 || execute_en_in || in_arithMemory) n_hit++;
      end
      chk("t3_rd_cycles", n_rd, 15);
      chk("t3_err_pre", mem_err, 0);
      tick();
      chk("t3_err", mem_err, 1);
      chk("t3_fetch", {instr_ready, pc, mem_rd}, {1'b1, 4'd1, 1'b0});
      tick();
      if (strb != 0 || execute_en_in) n_hit++;
      chk("t3_no_strobe", n_hit, 0);
      tick();
      chk("t3_err_sticky", {halted, mem_err}, 2'b11);

      // JMP 7, JMP 15, NOP at 15 wraps pc, then stall
      do_reset();
      prog[0] = 8'hC7; prog[7] = 8'hCF; prog[15] = 8'h00;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      chk("t4_jmp7", {instr_ready, pc}, {1'b1, 4'd7});
      tick(); tick();
      chk("t4_jmp15", {instr_ready, pc}, {1'b1, 4'd15});
      tick();
      chk("t4_wrap", pc, 0);
      instr_valid = 1'b0;
      tick(); tick(); tick();
      chk("t4_stall", {instr_ready, pc, busy}, {1'b1, 4'd0, 1'b1});
      instr_valid = 1'b1;

      // illegal, NOP, LDA, then an ADD interrupted by restart
      do_reset();
      prog[0] = 8'hD0; prog[1] = 8'h00; prog[2] = 8'h10; prog[3] = 8'h25;
      start = 1'b1; tick(); start = 1'b0;
      tick();
      chk("t5_dec_ill", illegal, 0);
      tick();
      chk("t5_ill", {illegal, instr_ready, pc}, {1'b1, 1'b1, 4'd1});
      chk("t5_ill_strb", {strb, execute_en_in, in_load_accu}, 0);
      tick(); tick();
      chk("t5_nop", {strb, execute_en_in, in_load_accu, instr_ready, pc}, {12'h0, 1'b1, 4'd2});
      tick(); tick();
      chk("t5_lda", {in_load_accu, execute_en_in, strb}, {1'b1, 1'b0, 10'h0});
      tick();
      chk("t5_lda_once", {in_load_accu, illegal}, 2'b01);
      tick(); tick();
      chk("t6_midread", {mem_rd, mem_addr}, {1'b1, 4'd5});
      do_reset();
      chk("t6_rst", {mem_rd, pc, busy, illegal, mem_err, instr_ready}, 0);
      prog[0] = 8'h33;
      start = 1'b1; tick(); start = 1'b0;
      chk("t6_refetch", {instr_ready, pc}, {1'b1, 4'd0});
      tick();
      chk("t6_refetch_pc", pc, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
